// File: rtl/seven_seg_capture.sv
// seven_seg_capture: recovers 4 hex digits from a multiplexed active-low 7-segment bus.
// Optional error counter output enabled by defining SEVEN_SEG_ERR_CNT_EN.
module seven_seg_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  anode,
   input  logic [6:0]  cathode,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic        frame_done,
   output logic        err
`ifdef SEVEN_SEG_ERR_CNT_EN
   ,
   output logic [7:0]  err_count
`endif
);
   typedef enum logic [1:0] {IDLE, SEEN0, SEEN1, SEEN2} state_t;
   state_t state, nxt;
   logic [10:0] s_cur, s_prev;
   logic [CNT_W-1:0] cnt;
   logic [3:0] an, nib;
   logic [6:0] seg;
   logic [1:0] idx;
   logic capture, one_hot, legal, err_set;
   assign {an, seg} = s_cur;
   // fires only on the step into saturation, so a held slot captures once
   assign capture = (s_cur == s_prev) && (cnt == CNT_W'(STABLE_CYCLES - 1));
   assign one_hot = (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
   assign idx = !an[0] ? 2'd0 : !an[1] ? 2'd1 : !an[2] ? 2'd2 : 2'd3;
   assign err_set = capture && (an != 4'hF) && (!one_hot || !legal);
   always_comb begin
      nib = 4'h0;
      legal = 1'b1;
      case (seg)
         7'b1000000: nib = 4'h0;
         7'b1111001: nib = 4'h1;
         7'b0100100: nib = 4'h2;
         7'b0110000: nib = 4'h3;
         7'b0011001: nib = 4'h4;
         7'b0010010: nib = 4'h5;
         7'b0000010: nib = 4'h6;
         7'b1111000: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0010000: nib = 4'h9;
         7'b0001000: nib = 4'hA;
         7'b0000011: nib = 4'hB;
         7'b1000110: nib = 4'hC;
         7'b0100001: nib = 4'hD;
         7'b0000110: nib = 4'hE;
         7'b0001110: nib = 4'hF;
         default:    legal = 1'b0;
      endcase
   end
   always_comb begin
      nxt = (idx == 2'd0) ? SEEN0 :
            (state == SEEN0 && idx == 2'd1) ? SEEN1 :
            (state == SEEN1 && idx == 2'd2) ? SEEN2 :
            ((state == SEEN1 && idx == 2'd1) || (state == SEEN2 && idx == 2'd2)) ? state : IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         s_cur       <= '1;
         s_prev      <= '1;
         cnt         <= '0;
         state       <= IDLE;
         digits      <= '0;
         digit_valid <= '0;
         frame_done  <= 1'b0;
         err         <= 1'b0;
      end else begin
         s_cur      <= {anode, cathode};
         s_prev     <= s_cur;
         cnt        <= (s_cur != s_prev) ? '0 : (cnt == CNT_W'(STABLE_CYCLES)) ? cnt : cnt + 1'b1;
         frame_done <= 1'b0;
         err        <= err_set;
         if (capture && an != 4'hF) begin
            if (!one_hot) begin
               state <= IDLE;
            end else if (!legal) begin
               digit_valid[idx] <= 1'b0;
               state            <= IDLE;
            end else begin
               digits[{idx, 2'b00} +: 4] <= nib;
               digit_valid[idx]          <= 1'b1;
               state                     <= nxt;
               frame_done                <= (state == SEEN2) && (idx == 2'd3);
            end
         end
      end
   end
`ifdef SEVEN_SEG_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) err_count <= '0;
      else if (err_set && err_count != 8'hFF) err_count <= err_count + 8'd1;
   end
`endif
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: scoreboard bench for seven_seg_capture; event pulses are matched
// against a queue of expected err/frame_done events built from a behavioural model.
module tb_seven_seg_capture;
   localparam int S = 4;
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   typedef struct packed {
      logic        e;
      logic        f;
      logic [15:0] d;
      logic [3:0]  v;
   } ev_t;
   logic clk = 1'b0, reset = 1'b1;
   logic [3:0] anode = 4'hF;
   logic [6:0] cathode = 7'h7F;
   logic [15:0] digits;
   logic [3:0] digit_valid;
   logic frame_done, err;
`ifdef SEVEN_SEG_ERR_CNT_EN
   logic [7:0] err_count;
`endif
   ev_t exp_q[$];
   logic [15:0] m_d = '0;
   logic [3:0] m_v = '0;
   int m_seen = -1, m_ec = 0;
   int errors = 0, checks = 0, frame_cnt = 0;

   seven_seg_capture #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .anode(anode), .cathode(cathode),
      .digits(digits), .digit_valid(digit_valid), .frame_done(frame_done), .err(err)
`ifdef SEVEN_SEG_ERR_CNT_EN
      , .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && (err || frame_done)) begin
         ev_t ev;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: err=%b frame_done=%b digits=%h valid=%b, required no event",
                     err, frame_done, digits, digit_valid);
         end else begin
            ev = exp_q.pop_front();
            if ({err, frame_done, digits, digit_valid} !== {ev.e, ev.f, ev.d, ev.v}) begin
               errors++;
               $display("FAIL event: got err=%b frame_done=%b digits=%h valid=%b, required err=%b frame_done=%b digits=%h valid=%b",
                        err, frame_done, digits, digit_valid, ev.e, ev.f, ev.d, ev.v);
            end
         end
         if (frame_done) frame_cnt++;
      end
   end

   task automatic do_reset(input int cyc);
      anode = 4'hF;
      cathode = 7'h7F;
      reset = 1'b1;
      repeat (cyc) @(negedge clk);
      reset = 1'b0;
      m_d = '0;
      m_v = '0;
      m_seen = -1;
      m_ec = 0;
   endtask

   // model of one bus slot held for cyc cycles; assumes the previous slot differs
   task automatic slot(input logic [3:0] a, input logic [6:0] c, input int cyc);
      int n, val;
      if (cyc >= S + 1 && a != 4'hF) begin
         n = (a == 4'b1110) ? 0 : (a == 4'b1101) ? 1 : (a == 4'b1011) ? 2 : (a == 4'b0111) ? 3 : -1;
         val = -1;
         for (int i = 0; i < 16; i++) if (GLYPH[i] == c) val = i;
         if (n < 0 || val < 0) begin
            if (n >= 0) m_v[n] = 1'b0;
            m_seen = -1;
            if (m_ec < 255) m_ec++;
            exp_q.push_back(ev_t'{1'b1, 1'b0, m_d, m_v});
         end else begin
            m_d[4*n +: 4] = 4'(val);
            m_v[n] = 1'b1;
            if (m_seen == 2 && n == 3) begin
               m_seen = -1;
               exp_q.push_back(ev_t'{1'b0, 1'b1, m_d, m_v});
            end else begin
               m_seen = (n == 0 || n == m_seen + 1 || n == m_seen) ? n : -1;
            end
         end
      end
      anode = a;
      cathode = c;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic test_reset;
      do_reset(2);
      checks += 4;
      if (digits !== 16'h0) begin errors++; $display("FAIL reset_digits: got %h, required 0000", digits); end
      if (digit_valid !== 4'h0) begin errors++; $display("FAIL reset_valid: got %b, required 0000", digit_valid); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b, required 0", frame_done); end
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
   endtask

   task automatic test_scan;
      int f0;
      f0 = frame_cnt;
      for (int r = 0; r < 2; r++) begin
         slot(4'b1110, GLYPH[0], 8);
         slot(4'b1101, GLYPH[9], 8);
         slot(4'b1011, GLYPH[4], 8);
         slot(4'b0111, GLYPH[15], 8);
      end
      slot(4'hF, 7'h7F, 4);
      checks += 3;
      if (digits !== 16'hF490) begin errors++; $display("FAIL scan_digits: got %h, required f490", digits); end
      if (digit_valid !== 4'hF) begin errors++; $display("FAIL scan_valid: got %b, required 1111", digit_valid); end
      if (frame_cnt - f0 !== 2) begin errors++; $display("FAIL scan_frames: got %0d, required 2", frame_cnt - f0); end
   endtask

   task automatic test_stable_boundary;
      do_reset(1);
      slot(4'b1110, GLYPH[3], S);
      slot(4'hF, 7'h7F, 8);
      checks++;
      if (digit_valid[0] !== 1'b0) begin errors++; $display("FAIL short_hold_valid: got %b, required 0", digit_valid[0]); end
      slot(4'b1110, GLYPH[3], S + 1);
      checks++;
      if (digit_valid[0] !== 1'b0) begin errors++; $display("FAIL early_valid: got %b, required 0", digit_valid[0]); end
      slot(4'hF, 7'h7F, 1);
      checks += 2;
      if (digit_valid[0] !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b, required 1", digit_valid[0]); end
      if (digits[3:0] !== 4'h3) begin errors++; $display("FAIL latency_digit: got %h, required 3", digits[3:0]); end
      slot(4'hF, 7'h7F, 6);
   endtask

   task automatic test_bad_anode;
      int f0;
      f0 = frame_cnt;
      slot(4'b1100, GLYPH[2], 10);
      checks += 2;
      if (digits !== 16'h0003) begin errors++; $display("FAIL bad_anode_digits: got %h, required 0003", digits); end
      if (digit_valid !== 4'b0001) begin errors++; $display("FAIL bad_anode_valid: got %b, required 0001", digit_valid); end
`ifdef SEVEN_SEG_ERR_CNT_EN
      checks++;
      if (err_count !== 8'd1) begin errors++; $display("FAIL err_count: got %0d, required 1", err_count); end
`endif
      slot(4'b1101, GLYPH[1], 8);
      slot(4'b1011, GLYPH[2], 8);
      slot(4'b0111, GLYPH[3], 8);
      checks++;
      if (frame_cnt !== f0) begin errors++; $display("FAIL bad_anode_idle: got %0d frames, required 0", frame_cnt - f0); end
   endtask

   task automatic test_illegal_glyph;
      slot(4'b1101, GLYPH[5], 8);
      slot(4'b1101, 7'h7F, 8);
      checks += 3;
      if (digit_valid[1] !== 1'b0) begin errors++; $display("FAIL illegal_valid1: got %b, required 0", digit_valid[1]); end
      if (digits[7:4] !== 4'h5) begin errors++; $display("FAIL illegal_digit1: got %h, required 5", digits[7:4]); end
      if ({digits, digit_valid} !== {m_d, m_v}) begin errors++; $display("FAIL illegal_state: got %h/%b, required %h/%b", digits, digit_valid, m_d, m_v); end
`ifdef SEVEN_SEG_ERR_CNT_EN
      checks++;
      if (err_count !== 8'(m_ec)) begin errors++; $display("FAIL err_count2: got %0d, required %0d", err_count, m_ec); end
`endif
   endtask

   task automatic test_order;
      int f0;
      f0 = frame_cnt;
      slot(4'b1110, GLYPH[1], 8);
      slot(4'b1011, GLYPH[2], 8);
      slot(4'b0111, GLYPH[3], 8);
      checks++;
      if (frame_cnt !== f0) begin errors++; $display("FAIL out_of_order: got %0d frames, required 0", frame_cnt - f0); end
      slot(4'b1110, GLYPH[10], 8);
      slot(4'b1101, GLYPH[7], 8);
      slot(4'b1101, GLYPH[8], 8);
      slot(4'b1011, GLYPH[12], 8);
      slot(4'b0111, GLYPH[14], 8);
      checks += 2;
      if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL repeat_index: got %0d frames, required 1", frame_cnt - f0); end
      if (digits !== 16'hEC8A) begin errors++; $display("FAIL repeat_digits: got %h, required ec8a", digits); end
   endtask

   task automatic test_reset_mid;
      int f0;
      slot(4'b1110, GLYPH[6], 8);
      slot(4'b1101, GLYPH[11], 8);
      do_reset(1);
      checks += 4;
      if (digits !== 16'h0) begin errors++; $display("FAIL mid_reset_digits: got %h, required 0000", digits); end
      if (digit_valid !== 4'h0) begin errors++; $display("FAIL mid_reset_valid: got %b, required 0000", digit_valid); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_reset_frame: got %b, required 0", frame_done); end
      if (err !== 1'b0) begin errors++; $display("FAIL mid_reset_err: got %b, required 0", err); end
      f0 = frame_cnt;
      slot(4'b1110, GLYPH[1], 8);
      slot(4'b1101, GLYPH[2], 8);
      slot(4'b1011, GLYPH[3], 8);
      slot(4'b0111, GLYPH[4], 8);
      checks += 2;
      if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL post_reset_frame: got %0d frames, required 1", frame_cnt - f0); end
      if (digits !== 16'h4321) begin errors++; $display("FAIL post_reset_digits: got %h, required 4321", digits); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_stable_boundary();
      test_bad_anode();
      test_illegal_glyph();
      test_order();
      test_reset_mid();
      slot(4'hF, 7'h7F, 8);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events: got %0d still pending, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
